// File: rtl/knapsack_result_tx.sv
// knapsack_result_tx: streams the DP result cache to the host as 8N1 UART.
// Define RESULT_TX_CHECKSUM_EN to append an 8-bit sum byte to each packet.
module knapsack_result_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_CAP      = 64,
  parameter int AW           = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW:0]   count,
  output logic [AW-1:0] rd_addr,
  input  logic [31:0]   rd_data,
  output logic          Tx_Serial,
  output logic          busy,
  output logic          send_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE
  } state_t;

  typedef enum logic [1:0] {
    SEL_HDR, SEL_CNT, SEL_WORD, SEL_SUM
  } sel_t;

  state_t        state, state_n;
  sel_t          sel, sel_n;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg, byte_n;
  logic [1:0]    byte_cnt, bcnt_n;
  logic [AW:0]   n_q, left, clamp;
  logic [AW-1:0] word_idx;
  logic [31:0]   hold;
  logic          fetch_q, cap_q;
  logic          bit_end, more, fetch_go;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  assign bit_end = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign clamp = (count > (AW+1)'(MAX_CAP)) ?
                 (AW+1)'(MAX_CAP) : count;
  assign fetch_go = (state == START) && bit_end &&
                    (((sel == SEL_CNT) && (n_q != '0)) ||
                     ((sel == SEL_WORD) && (byte_cnt == 2'd3) &&
                      (left > (AW+1)'(1))));

  // choose the byte that follows the one finishing its stop bit
  always_comb begin
    more   = 1'b1;
    sel_n  = sel;
    byte_n = 8'h00;
    bcnt_n = byte_cnt;
    unique case (sel)
      SEL_HDR: begin
        sel_n  = SEL_CNT;
        byte_n = 8'(n_q);
      end
      SEL_CNT: begin
        if (n_q != '0) begin
          sel_n  = SEL_WORD;
          bcnt_n = 2'd0;
          byte_n = hold[7:0];
        end else begin
`ifdef RESULT_TX_CHECKSUM_EN
          sel_n  = SEL_SUM;
          byte_n = sum;
`else
          more   = 1'b0;
`endif
        end
      end
      SEL_WORD: begin
        if (byte_cnt != 2'd3) begin
          bcnt_n = byte_cnt + 2'd1;
          byte_n = hold[{bcnt_n, 3'b000} +: 8];
        end else if (left > (AW+1)'(1)) begin
          bcnt_n = 2'd0;
          byte_n = hold[7:0];
        end else begin
`ifdef RESULT_TX_CHECKSUM_EN
          sel_n  = SEL_SUM;
          byte_n = sum;
`else
          more   = 1'b0;
`endif
        end
      end
      SEL_SUM: more = 1'b0;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next-state: bytes chain back-to-back with no idle gap
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = START;
      START: if (bit_end) state_n = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_n = STOP;
      STOP:  if (bit_end) state_n = more ? START : DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // line and status outputs decoded from state
  always_comb begin
    Tx_Serial = 1'b1;
    busy      = 1'b0;
    send_done = 1'b0;
    unique case (state)
      START: begin Tx_Serial = 1'b0; busy = 1'b1; end
      DATA:  begin Tx_Serial = shreg[0]; busy = 1'b1; end
      STOP:  busy = 1'b1;
      DONE:  send_done = 1'b1;
      default: ;
    endcase
  end

  // bit timing, serializer, byte sequencing and word fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel      <= SEL_HDR;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= 8'hFF;
      byte_cnt <= '0;
      n_q      <= '0;
      left     <= '0;
      word_idx <= '0;
      hold     <= '0;
      rd_addr  <= '0;
      fetch_q  <= 1'b0;
      cap_q    <= 1'b0;
`ifdef RESULT_TX_CHECKSUM_EN
      sum      <= '0;
`endif
    end else begin
      fetch_q <= fetch_go;
      cap_q   <= fetch_q;
      if (state inside {START, DATA, STOP} && !bit_end)
        clk_cnt <= clk_cnt + 1'b1;
      else
        clk_cnt <= '0;
      if (state == IDLE && start) begin
        n_q      <= clamp;
        left     <= clamp;
        sel      <= SEL_HDR;
        shreg    <= 8'hA5;
        bit_idx  <= '0;
        byte_cnt <= '0;
        word_idx <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
        sum      <= '0;
`endif
      end
      if (state == DATA && bit_end) begin
        shreg   <= {1'b1, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == STOP && bit_end) begin
        if (sel == SEL_WORD && byte_cnt == 2'd3)
          left <= left - 1'b1;
        if (more) begin
          shreg    <= byte_n;
          sel      <= sel_n;
          byte_cnt <= bcnt_n;
`ifdef RESULT_TX_CHECKSUM_EN
          if (sel_n != SEL_SUM) sum <= sum + byte_n;
`endif
        end
      end
      if (fetch_go) rd_addr <= word_idx;
      if (cap_q) begin
        hold     <= rd_data;
        word_idx <= word_idx + 1'b1;
      end
    end
  end

endmodule
